// File: rtl/scroll_pointer_ctrl_if.sv
// Button/switch inputs and pointer outputs of the scroll pointer controller.
// The master drives the raw buttons; the controller (slave) drives the pointer side.
interface scroll_pointer_ctrl_if;
  logic       btn_step;
  logic       btn_mode;
  logic       dir;
  logic [3:0] pointer;
  logic       auto_mode;
  logic       step_pulse;

  modport master (
    output btn_step, btn_mode, dir,
    input  pointer, auto_mode, step_pulse
  );

  modport slave (
    input  btn_step, btn_mode, dir,
    output pointer, auto_mode, step_pulse
  );
endinterface

// File: rtl/scroll_pointer_ctrl.sv
// Message pointer controller for the rotating seven-segment display.
// Provides auto/manual rotation, a debounced manual step and direction control.
module scroll_pointer_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  output logic press_o
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // The count holds the number of stable samples seen so far; the sample that
  // would bring it to DEBOUNCE_CYCLES completes the transition instead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sync_i) begin
          state_d = ARMING;
          cnt_d   = CNT_ONE;
        end
      end
      ARMING: begin
        if (!sync_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync_i) begin
          state_d = RELEASING;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASING: begin
        if (sync_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d = (state_q == ARMING) && sync_i && (cnt_q == CNT_LAST);
  end

  assign press_o = press_q;
endmodule

module scroll_pointer_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int STEP_PERIOD     = 8388607
) (
  input  logic                 clk,
  input  logic                 reset,
  scroll_pointer_ctrl_if.slave bus
);
  localparam int PER_W = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(STEP_PERIOD - 1);
  localparam logic [PER_W-1:0] PER_ONE    = PER_W'(1);

  // Bit order in the synchronizer vectors: {dir, mode, step}.
  logic [2:0]       meta_q, sync_q;
  logic             step_press, mode_press;
  logic [PER_W-1:0] period_q, period_d;
  logic [3:0]       pointer_q, pointer_d;
  logic             auto_q, auto_d;
  logic             pulse_q, pulse_d;
  logic             expire, do_step;

  function automatic logic [3:0] step_ptr(input logic [3:0] ptr, input logic dec);
    return dec ? (ptr - 4'd1) : (ptr + 4'd1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {bus.dir, bus.btn_mode, bus.btn_step};
      sync_q <= meta_q;
    end
  end

  scroll_pointer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk     (clk),
    .reset   (reset),
    .sync_i  (sync_q[0]),
    .press_o (step_press)
  );

  scroll_pointer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .reset   (reset),
    .sync_i  (sync_q[1]),
    .press_o (mode_press)
  );

  // A timer expiry is ignored while the mode is toggling, since the mode change
  // restarts the period; a step press always wins and merges with an expiry.
  always_comb begin
    auto_d    = auto_q ^ mode_press;
    expire    = auto_q && !mode_press && (period_q == '0);
    do_step   = step_press || expire;
    period_d  = period_q - PER_ONE;
    if (!auto_d || mode_press || do_step) begin
      period_d = PER_RELOAD;
    end
    pointer_d = do_step ? step_ptr(pointer_q, sync_q[2]) : pointer_q;
    pulse_d   = do_step;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q  <= PER_RELOAD;
      pointer_q <= '0;
      auto_q    <= 1'b1;
      pulse_q   <= 1'b0;
    end else begin
      period_q  <= period_d;
      pointer_q <= pointer_d;
      auto_q    <= auto_d;
      pulse_q   <= pulse_d;
    end
  end

  assign bus.pointer    = pointer_q;
  assign bus.auto_mode  = auto_q;
  assign bus.step_pulse = pulse_q;
endmodule

// File: tb/tb_scroll_pointer_ctrl.sv
// Directed bench for scroll_pointer_ctrl with DEBOUNCE_CYCLES=4, STEP_PERIOD=10.
// Edge numbers in comments count rising clk edges after the last input change.
module tb_scroll_pointer_ctrl;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   pulses;

  scroll_pointer_ctrl_if bus_if ();

  scroll_pointer_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_PERIOD(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pulses += int'(bus_if.step_pulse);
    end
  endtask

  task automatic press_step();
    bus_if.btn_step = 1'b1;
    tick(10);
    bus_if.btn_step = 1'b0;
    tick(10);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pulses = 0;
    reset  = 1'b0;
    bus_if.btn_step = 1'b0;
    bus_if.btn_mode = 1'b0;
    bus_if.dir      = 1'b0;

    // Asynchronous reset takes effect before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_pointer", int'(bus_if.pointer), 0);
    check("rst_auto", int'(bus_if.auto_mode), 1);
    check("rst_pulse", int'(bus_if.step_pulse), 0);
    tick(2);
    reset = 1'b0;

    // Free-running auto steps at edges 10, 20, 30
    tick(9);
    check("auto_pre_ptr", int'(bus_if.pointer), 0);
    check("auto_pre_pulse", int'(bus_if.step_pulse), 0);
    tick(1);
    check("auto1_ptr", int'(bus_if.pointer), 1);
    check("auto1_pulse", int'(bus_if.step_pulse), 1);
    tick(1);
    check("auto1_pulse_low", int'(bus_if.step_pulse), 0);
    tick(9);
    check("auto2_ptr", int'(bus_if.pointer), 2);
    check("auto2_pulse", int'(bus_if.step_pulse), 1);
    tick(10);
    check("auto3_ptr", int'(bus_if.pointer), 3);
    check("auto3_pulse", int'(bus_if.step_pulse), 1);
    check("auto3_mode", int'(bus_if.auto_mode), 1);
    tick(5);

    // Fresh reset, then mode press toggles to manual at edge 7 (before first expiry)
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus_if.btn_mode = 1'b1;
    tick(6);
    check("mode_pre", int'(bus_if.auto_mode), 1);
    tick(1);
    check("mode_manual", int'(bus_if.auto_mode), 0);
    check("mode_ptr", int'(bus_if.pointer), 0);
    tick(1);
    bus_if.btn_mode = 1'b0;
    tick(10);

    // Manual step press, latency 7 edges, single pulse while held 20 cycles
    bus_if.btn_step = 1'b1;
    tick(6);
    check("man_lat_ptr", int'(bus_if.pointer), 0);
    check("man_lat_pulse", int'(bus_if.step_pulse), 0);
    tick(1);
    check("man_step_ptr", int'(bus_if.pointer), 1);
    check("man_step_pulse", int'(bus_if.step_pulse), 1);
    tick(1);
    check("man_pulse_low", int'(bus_if.step_pulse), 0);
    tick(12);
    bus_if.btn_step = 1'b0;
    pulses = 0;
    tick(50);
    check("man_idle_pulses", pulses, 0);
    check("man_idle_ptr", int'(bus_if.pointer), 1);
    check("man_idle_mode", int'(bus_if.auto_mode), 0);

    // Decrement wrap 0 -> 15, increment wrap 15 -> 0
    bus_if.dir = 1'b1;
    tick(4);
    press_step();
    check("dec_to0", int'(bus_if.pointer), 0);
    press_step();
    check("dec_wrap", int'(bus_if.pointer), 15);
    bus_if.dir = 1'b0;
    tick(4);
    press_step();
    check("inc_wrap", int'(bus_if.pointer), 0);

    // Glitches shorter than the debounce window are rejected
    pulses = 0;
    bus_if.btn_step = 1'b1;
    tick(3);
    bus_if.btn_step = 1'b0;
    tick(2);
    bus_if.btn_step = 1'b1;
    tick(3);
    bus_if.btn_step = 1'b0;
    tick(12);
    check("glitch_pulses", pulses, 0);
    check("glitch_ptr", int'(bus_if.pointer), 0);

    // Back to auto (edge 7); press lands at edge 14, 3 before expiry at 17
    bus_if.btn_mode = 1'b1;
    tick(7);
    check("auto_again", int'(bus_if.auto_mode), 1);
    bus_if.btn_step = 1'b1;
    tick(1);
    bus_if.btn_mode = 1'b0;
    tick(5);
    check("merge_pre_ptr", int'(bus_if.pointer), 0);
    tick(1);
    check("merge_press_ptr", int'(bus_if.pointer), 1);
    check("merge_press_pulse", int'(bus_if.step_pulse), 1);
    tick(3);
    check("merge_no_old_expiry_ptr", int'(bus_if.pointer), 1);
    check("merge_no_old_expiry_pulse", int'(bus_if.step_pulse), 0);
    tick(1);
    bus_if.btn_step = 1'b0;
    tick(5);
    check("merge_pre_next_pulse", int'(bus_if.step_pulse), 0);
    tick(1);
    check("merge_next_ptr", int'(bus_if.pointer), 2);
    check("merge_next_pulse", int'(bus_if.step_pulse), 1);

    // Button held through reset: no step in the first 6 edges after release of reset
    bus_if.btn_step = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    pulses = 0;
    tick(6);
    check("hold_rst_pulses", pulses, 0);
    check("hold_rst_ptr", int'(bus_if.pointer), 0);
    tick(1);
    check("hold_rst_arm_ptr", int'(bus_if.pointer), 1);
    bus_if.btn_step = 1'b0;
    pulses = 0;
    tick(6);
    bus_if.btn_step = 1'b1;
    tick(4);
    check("hold_rst_auto_ptr", int'(bus_if.pointer), 2);
    check("hold_rst_auto_pulse", int'(bus_if.step_pulse), 1);
    tick(2);
    check("repress_pre_pulse", int'(bus_if.step_pulse), 0);
    tick(1);
    check("repress_ptr", int'(bus_if.pointer), 3);
    check("repress_pulse", int'(bus_if.step_pulse), 1);
    tick(1);
    check("repress_pulses", pulses, 2);
    bus_if.btn_step = 1'b0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
